// File: rtl/wb_arbiter.sv
// Round-robin arbiter that shares one writeback slot between NUM_REQ execution units.
// The grant is combinational; the winner's payload is registered onto the WB port.
module wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 72
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_wb_block,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_wb_valid,
  output logic [DATA_W-1:0]          o_wb_data,
  output logic [$clog2(NUM_REQ)-1:0] o_wb_src
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   L_NUM  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] L_LAST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_wb_valid;
  logic [DATA_W-1:0]  r_wb_data;
  logic [IDX_W-1:0]   r_wb_src;

  logic               w_grant_en;
  logic               w_any;
  logic               w_take;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W:0]     w_pos;
  logic [DATA_W-1:0]  w_sel_data;

  assign w_grant_en = ~i_flush & ~i_wb_block;

  // Search upward from r_rr_ptr, wrapping modulo NUM_REQ; first valid request wins.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    w_sum     = '0;
    w_pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      w_pos = (w_sum >= L_NUM) ? (w_sum - L_NUM) : w_sum;
      if (!w_any && i_req_valid[w_pos[IDX_W-1:0]]) begin
        w_any                         = 1'b1;
        w_grant[w_pos[IDX_W-1:0]]     = 1'b1;
        w_gnt_idx                     = w_pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) w_sel_data = i_req_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_take  = w_any & w_grant_en & i_rst_n;
  assign o_grant = w_grant & {NUM_REQ{w_grant_en & i_rst_n}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_src   <= '0;
    end else begin
      r_wb_valid <= w_take;
      if (w_take) begin
        r_wb_data <= w_sel_data;
        r_wb_src  <= w_gnt_idx;
        r_rr_ptr  <= (w_gnt_idx == L_LAST) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_data  = r_wb_data;
  assign o_wb_src   = r_wb_src;

endmodule
